// File: rtl/types.sv
// -----------------------------------------------------------------------------
// types
//   Shared pipeline types. instr_t is the raw 32-bit instruction word handed
//   from fetch to decode (immediate generator and control decoder).
// -----------------------------------------------------------------------------
package types;

   typedef logic [31:0] instr_t;

endpackage : types

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Small in-order synchronous FIFO holding fetched {instr, pc} pairs.
//   The head entry is driven straight from storage (no output register).
//
// Parameters
//   QDEPTH      number of entries (>= 1)
//   W           payload width
//
// Ports
//   clk          in   clock, rising edge
//   rstn         in   asynchronous active-low reset
//   flush_i      in   empty the queue; overrides a same-cycle push and pop
//   push_i       in   write push_data_i at the tail
//   push_data_i  in   payload to write
//   pop_i        in   drop the head entry (ignored when empty)
//   head_o       out  payload at the head
//   count_o      out  current occupancy
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int QDEPTH = 2,
   parameter int W      = 64
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         flush_i,
   input  logic                         push_i,
   input  logic [W-1:0]                 push_data_i,
   input  logic                         pop_i,
   output logic [W-1:0]                 head_o,
   output logic [$clog2(QDEPTH+1)-1:0]  count_o
);

   localparam int            CW   = $clog2(QDEPTH+1);
   localparam int            PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(QDEPTH-1);

   logic [W-1:0]  mem_q [QDEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   // Pointers wrap explicitly so QDEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // The fetch credit scheme reserves a slot for every outstanding request,
   // so a push into a full queue means the accounting upstream is broken.
   assert property (@(posedge clk) disable iff (!rstn)
      !(push_i && !flush_i && (count_q == CW'(QDEPTH))));

endmodule : fetch_queue

// File: rtl/ifetch.sv
// -----------------------------------------------------------------------------
// ifetch
//   Instruction fetch stage. Owns the fetch PC, issues word requests to
//   instruction memory, buffers returned words in fetch_queue and presents
//   the head {instr, pc} to decode. Execute may redirect fetch; a redirect
//   flushes the queue and discards responses still in flight.
//
// Handshakes: every valid/ready pair transfers exactly when valid && ready
//   are both high at the rising clock edge. imem_req_valid may drop without
//   a transfer only in a redirect cycle or when a decode pop is withdrawn.
//   imem_rsp_valid has no ready: every response is taken in its cycle.
//
// Parameters
//   RESET_PC   fetch address after reset
//   QDEPTH     queue entries; also the cap on outstanding + queued words
//
// Ports
//   clk, rstn                    clock, asynchronous active-low reset
//   redirect_valid, redirect_pc  redirect request from execute
//   imem_req_valid/ready, imem_addr     request channel to memory
//   imem_rsp_valid, imem_rdata          in-order response channel
//   instr_valid/ready, instr, instr_pc  head of queue to decode
// -----------------------------------------------------------------------------
module ifetch
   import types::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output instr_t      instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int CW = $clog2(QDEPTH+1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   rsp_pc_q,   rsp_pc_d;
   logic [CW-1:0] outst_q,    outst_d;
   logic [CW-1:0] drop_q,     drop_d;
   logic [CW-1:0] q_count;
   logic [CW:0]   credit_used;
   logic [63:0]   q_head;
   logic [31:0]   redirect_base;
   logic          pop;
   logic          req_fire;
   logic          push;
   logic          unused_redirect_lsbs;

   assign redirect_base        = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   assign instr_valid = (q_count != '0);
   assign pop         = instr_valid && instr_ready;

   // Every accepted request owns a queue slot until its word is popped, so
   // the slot freed by this cycle's pop can be reused immediately.
   assign credit_used    = {1'b0, outst_q} + {1'b0, q_count} - (CW+1)'(pop);
   assign imem_req_valid = rstn && !redirect_valid &&
                           (credit_used < (CW+1)'(QDEPTH));
   assign imem_addr      = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Responses belonging to pre-redirect requests are discarded, as is any
   // response landing in the redirect cycle itself.
   assign push = imem_rsp_valid && !redirect_valid && (drop_q == '0);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_d     = drop_q;
      outst_d    = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
         fetch_pc_d = redirect_base;
         rsp_pc_d   = redirect_base;
         drop_d     = outst_q - CW'(imem_rsp_valid);
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (imem_rsp_valid) begin
            if (drop_q != '0) drop_d   = drop_q - 1'b1;
            else              rsp_pc_d = rsp_pc_q + 32'd4;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
      end
   end

   fetch_queue #(
      .QDEPTH (QDEPTH),
      .W      (64)
   ) u_queue (
      .clk         (clk),
      .rstn        (rstn),
      .flush_i     (redirect_valid),
      .push_i      (push),
      .push_data_i ({imem_rdata, rsp_pc_q}),
      .pop_i       (pop),
      .head_o      (q_head),
      .count_o     (q_count)
   );

   assign instr    = q_head[63:32];
   assign instr_pc = q_head[31:0];

   assert property (@(posedge clk) disable iff (!rstn)
      imem_rsp_valid |-> (outst_q != '0));
   assert property (@(posedge clk) disable iff (!rstn)
      drop_q <= outst_q);

endmodule : ifetch

// File: tb/tb_ifetch.sv
module tb_ifetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0100;
   localparam int          QDEPTH   = 2;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   always #5 clk = ~clk;

   ifetch #(
      .RESET_PC (RESET_PC),
      .QDEPTH   (QDEPTH)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready)
   );

   // ---------------- bookkeeping ----------------
   int          n_vec = 0;
   int          n_err = 0;
   int          n_pop = 0;
   int          n_acc = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Instruction word stored at an address: any fixed function of the address.
   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // ---------------- reference model ----------------
   // Architecturally, decode must see a plain sequential PC stream starting
   // at the last reset/redirect target, each carrying memfn(pc).
   logic [31:0] exp_q[$];
   logic [31:0] next_pc;

   task automatic topup();
      while (exp_q.size() < 8) begin
         exp_q.push_back(next_pc);
         next_pc = next_pc + 32'd4;
      end
   endtask

   task automatic start_stream(input logic [31:0] pc);
      exp_q.delete();
      next_pc = pc;
      topup();
   endtask

   // ---------------- instruction memory model ----------------
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] due;
   } mreq_t;

   mreq_t mq[$];
   mreq_t mtmp;
   int    lat      = 1;   // minimum response latency in cycles
   int    rdy_mode = 0;   // 0: always ready, 1: stalled, 2: random
   bit    jitter   = 1'b0;

   initial begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rdata     = '0;
      forever begin
         @(posedge clk);
         #2;
         if (!rstn) mq.delete();
         case (rdy_mode)
            0:       imem_req_ready = 1'b1;
            1:       imem_req_ready = 1'b0;
            default: imem_req_ready = ($urandom_range(0, 3) != 0);
         endcase
         imem_rsp_valid = 1'b0;
         imem_rdata     = $urandom;
         if (rstn && mq.size() != 0 && mq[0].due <= cyc &&
             (!jitter || $urandom_range(0, 3) != 0)) begin
            imem_rsp_valid = 1'b1;
            imem_rdata     = memfn(mq[0].addr);
         end
         @(negedge clk);
         if (!rstn) begin
            mq.delete();
         end else begin
            if (imem_rsp_valid) void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready) begin
               mtmp.addr = imem_addr;
               mtmp.due  = cyc + lat;
               mq.push_back(mtmp);
               n_acc++;
            end
            chk("credit_cap", (mq.size() <= QDEPTH), 1);
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [31:0] mon_e;

   always @(negedge clk) begin
      if (rstn && instr_valid && instr_ready && !redirect_valid) begin
         n_pop++;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL pop_unexpected: got pc %h with no expected entry", instr_pc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pop_pc", instr_pc, mon_e);
            chk("pop_instr", instr, memfn(mon_e));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc_begin();
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      topup();
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      start_stream({pc[31:2], 2'b00});
   endtask

   // Leaves the bench at the start of the first cycle after reset release.
   task automatic do_reset();
      @(posedge clk);
      #1;
      rstn           = 1'b0;
      redirect_valid = 1'b0;
      start_stream(RESET_PC);
      @(negedge clk);
      chk("rst_req_valid",   imem_req_valid, 0);
      chk("rst_instr_valid", instr_valid,    0);
      chk("rst_addr",        imem_addr,      RESET_PC);
      chk("rst_instr",       instr,          0);
      chk("rst_instr_pc",    instr_pc,       0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      topup();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      n_vec++;
      n_err++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // ---------------- stimulus ----------------
   int          base;
   int          pops_before;
   bit          found;
   logic [31:0] stall_addr;
   logic [31:0] rpc;
   int          r;

   initial begin
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b0;
      next_pc        = RESET_PC;

      // Reset fetch: 1-cycle memory, decode always ready.
      instr_ready = 1'b1;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         if (c > 0) cyc_begin();
         @(negedge clk);
         chk("t1_req_valid", imem_req_valid, 1);
         chk("t1_addr", imem_addr, RESET_PC + 32'(4 * c));
         if (c < 2) begin
            chk("t1_instr_valid", instr_valid, 0);
         end else begin
            chk("t1_instr_valid", instr_valid, 1);
            chk("t1_instr_pc", instr_pc, RESET_PC + 32'(4 * (c - 2)));
         end
      end

      // Backpressure: decode stalled for 10 cycles.
      instr_ready = 1'b0;
      do_reset();
      base = n_acc;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) cyc_begin();
         @(negedge clk);
         if (c >= 2) begin
            chk("t2_held_valid", instr_valid, 1);
            chk("t2_held_pc", instr_pc, RESET_PC);
         end
      end
      cyc_begin();
      chk("t2_req_count", 32'(n_acc - base), QDEPTH);
      cyc_begin();
      instr_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) cyc_begin();
         @(negedge clk);
         chk("t2_resume_valid", instr_valid, 1);
         chk("t2_resume_pc", instr_pc, RESET_PC + 32'(4 * c));
      end

      // Redirect with two responses in flight, 3-cycle memory.
      lat = 3;
      instr_ready = 1'b1;
      do_reset();
      @(negedge clk);
      cyc_begin();
      @(negedge clk);
      cyc_begin();
      chk("t3_outstanding", mq.size(), 2);
      redirect(32'h0000_2002);
      @(negedge clk);
      chk("t3_no_req_in_redirect", imem_req_valid, 0);
      cyc_begin();
      @(negedge clk);
      chk("t3_flushed", instr_valid, 0);
      chk("t3_addr", imem_addr, 32'h0000_2000);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cyc_begin();
         @(negedge clk);
         if (instr_valid) found = 1'b1;
      end
      chk("t3_valid_seen", found, 1);
      chk("t3_first_pc", instr_pc, 32'h0000_2000);

      // Redirect coinciding with a response and a pop, 1-cycle memory.
      lat = 1;
      do_reset();
      repeat (5) cyc_begin();
      cyc_begin();
      redirect(32'h0000_3000);
      @(negedge clk);
      chk("t4_rsp_in_redirect", imem_rsp_valid, 1);
      chk("t4_pop_offered", instr_valid, 1);
      cyc_begin();
      @(negedge clk);
      chk("t4_n1_valid", instr_valid, 0);
      chk("t4_n1_req", imem_req_valid, 1);
      chk("t4_n1_addr", imem_addr, 32'h0000_3000);
      cyc_begin();
      @(negedge clk);
      chk("t4_n2_valid", instr_valid, 0);
      cyc_begin();
      @(negedge clk);
      chk("t4_n3_valid", instr_valid, 1);
      chk("t4_n3_pc", instr_pc, 32'h0000_3000);

      // Stalled memory for 5 cycles, then redirect near the top of memory.
      cyc_begin();
      rdy_mode = 1;
      @(negedge clk);
      stall_addr = imem_addr;
      chk("t5_stall_addr", imem_addr, 32'h0000_300C);
      chk("t5_stall_req", imem_req_valid, 1);
      for (int i = 1; i < 5; i++) begin
         cyc_begin();
         @(negedge clk);
         chk("t5_addr_stable", imem_addr, stall_addr);
         chk("t5_stall_req", imem_req_valid, 1);
      end
      cyc_begin();
      rdy_mode = 0;
      redirect(32'hFFFF_FFF8);
      cyc_begin();
      @(negedge clk);
      chk("t5_wrap_addr", imem_addr, 32'hFFFF_FFF8);
      cyc_begin();
      for (int k = 0; k < 3; k++) begin
         cyc_begin();
         @(negedge clk);
         chk("t5_wrap_valid", instr_valid, 1);
         chk("t5_wrap_pc", instr_pc, 32'hFFFF_FFF8 + 32'(4 * k));
      end

      // Reset pulsed mid-stream, then restart at RESET_PC.
      do_reset();
      @(negedge clk);
      chk("t5_restart_req", imem_req_valid, 1);
      chk("t5_restart_addr", imem_addr, RESET_PC);

      // Randomised traffic: backpressure, memory stalls, jitter, redirects.
      rdy_mode    = 2;
      jitter      = 1'b1;
      pops_before = n_pop;
      for (int i = 0; i < 3000; i++) begin
         cyc_begin();
         instr_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) lat = $urandom_range(1, 4);
         r = $urandom_range(0, 999);
         if (r < 3) begin
            do_reset();
         end else if (r < 50) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'h0000_000F);
            redirect(rpc);
         end
      end
      cyc_begin();
      rdy_mode    = 0;
      jitter      = 1'b0;
      instr_ready = 1'b1;
      repeat (20) cyc_begin();
      chk("t6_progress", ((n_pop - pops_before) > 200), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_ifetch
